// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c request arbiter: FSM encoding, field widths and
// default master limits.
package i2c_pkg;

   localparam int unsigned ByteW    = 8;
   localparam int unsigned LenW     = 8;
   localparam int unsigned DefWrMax = 2;
   localparam int unsigned DefRdMax = 2;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StCheck = 3'd1,
      StStart = 3'd2,
      StRun   = 3'd3,
      StFin   = 3'd4,
      StGap   = 3'd5
   } state_e;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping around.
module i2c_rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PtrW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PtrW-1:0] i_ptr,
   output logic [NREQ-1:0] o_onehot,
   output logic [PtrW-1:0] o_idx,
   output logic            o_any
);

   int unsigned w_j;

   // Scan from the farthest offset down to offset 0 so the closest hit wins.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      w_j      = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_j = (32'(i_ptr) + (NREQ - 1 - k)) % NREQ;
         if (i_req[PtrW'(w_j)]) begin
            o_idx = PtrW'(w_j);
            o_any = 1'b1;
         end
      end
      o_onehot[o_idx] = o_any;
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c byte-master among NREQ requesters; latches
// the winner's request, runs the enable/busy handshake and returns the response.
module i2c_req_arbiter
   import i2c_pkg::*;
#(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned WR_MAX   = DefWrMax,
   parameter int unsigned RD_MAX   = DefRdMax,
   parameter int unsigned START_TO = 255,
   parameter int unsigned GAP_CYC  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ*WR_MAX*ByteW-1:0] req_wrdata,
   input  logic [NREQ*LenW-1:0]        req_wrlen,
   input  logic [NREQ*LenW-1:0]        req_rdlen,
   output logic [NREQ-1:0]             gnt,
   output logic [NREQ-1:0]             done,
   output logic [RD_MAX*ByteW-1:0]     rsp_rddata,
   output logic                        rsp_ack,
   output logic                        rsp_err,
   output logic                        m_enable,
   input  logic                        m_busy,
   output logic [WR_MAX*ByteW-1:0]     m_wrdata,
   output logic [LenW-1:0]             m_wrlen,
   output logic [LenW-1:0]             m_rdlen,
   input  logic [RD_MAX*ByteW-1:0]     m_rddata,
   input  logic                        m_isack
);

   localparam int unsigned PtrW   = $clog2(NREQ);
   localparam int unsigned WrW    = WR_MAX * ByteW;
   localparam int unsigned RdW    = RD_MAX * ByteW;
   localparam int unsigned CntMax = (START_TO > GAP_CYC) ? START_TO : GAP_CYC;
   localparam int unsigned CntW   = $clog2(CntMax + 2);

   state_e           r_state, w_state_d;
   logic [PtrW-1:0]  r_ptr, w_ptr_d;
   logic [NREQ-1:0]  r_gnt, w_gnt_d;
   logic             r_en, w_en_d;
   logic [WrW-1:0]   r_wrdata, w_wrdata_d;
   logic [LenW-1:0]  r_wrlen, w_wrlen_d;
   logic [LenW-1:0]  r_rdlen, w_rdlen_d;
   logic [CntW-1:0]  r_cnt, w_cnt_d;
   logic [RdW-1:0]   r_rddata, w_rddata_d;
   logic             r_ack, w_ack_d;
   logic             r_err, w_err_d;

   logic [NREQ-1:0]  w_onehot;
   logic [PtrW-1:0]  w_idx;
   logic             w_any;
   logic             w_bad_len;

   i2c_rr_pick #(
      .NREQ (NREQ),
      .PtrW (PtrW)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_onehot (w_onehot),
      .o_idx    (w_idx),
      .o_any    (w_any)
   );

   assign w_bad_len = (r_wrlen > LenW'(WR_MAX)) || (r_rdlen > LenW'(RD_MAX)) ||
                      ((r_wrlen == '0) && (r_rdlen == '0));

   always_comb begin
      w_state_d  = r_state;
      w_ptr_d    = r_ptr;
      w_gnt_d    = r_gnt;
      w_en_d     = r_en;
      w_wrdata_d = r_wrdata;
      w_wrlen_d  = r_wrlen;
      w_rdlen_d  = r_rdlen;
      w_cnt_d    = r_cnt;
      w_rddata_d = r_rddata;
      w_ack_d    = r_ack;
      w_err_d    = r_err;
      unique case (r_state)
         StIdle: begin
            // A still-busy master from an aborted transfer blocks new grants.
            if (w_any && !m_busy) begin
               w_gnt_d = w_onehot;
               for (int unsigned i = 0; i < NREQ; i++) begin
                  if (w_idx == PtrW'(i)) begin
                     w_wrdata_d = req_wrdata[i*WrW +: WrW];
                     w_wrlen_d  = req_wrlen[i*LenW +: LenW];
                     w_rdlen_d  = req_rdlen[i*LenW +: LenW];
                  end
               end
               w_ptr_d   = (w_idx == PtrW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
               w_state_d = StCheck;
            end
         end
         StCheck: begin
            if (w_bad_len) begin
               w_err_d   = 1'b1;
               w_ack_d   = 1'b0;
               w_state_d = StFin;
            end else begin
               w_en_d    = 1'b1;
               w_cnt_d   = '0;
               w_state_d = StStart;
            end
         end
         StStart: begin
            if (m_busy) begin
               w_state_d = StRun;
            end else if (32'(r_cnt) + 1 >= START_TO) begin
               w_en_d    = 1'b0;
               w_err_d   = 1'b1;
               w_ack_d   = 1'b0;
               w_state_d = StFin;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         StRun: begin
            if (!m_busy) begin
               w_en_d     = 1'b0;
               w_rddata_d = m_rddata;
               w_ack_d    = m_isack;
               w_err_d    = 1'b0;
               w_state_d  = StFin;
            end
         end
         StFin: begin
            w_gnt_d   = '0;
            w_cnt_d   = '0;
            w_state_d = (GAP_CYC == 0) ? StIdle : StGap;
         end
         StGap: begin
            if (32'(r_cnt) + 1 >= GAP_CYC) begin
               w_state_d = StIdle;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= StIdle;
         r_ptr    <= '0;
         r_gnt    <= '0;
         r_en     <= 1'b0;
         r_wrdata <= '0;
         r_wrlen  <= '0;
         r_rdlen  <= '0;
         r_cnt    <= '0;
         r_rddata <= '0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_ptr    <= w_ptr_d;
         r_gnt    <= w_gnt_d;
         r_en     <= w_en_d;
         r_wrdata <= w_wrdata_d;
         r_wrlen  <= w_wrlen_d;
         r_rdlen  <= w_rdlen_d;
         r_cnt    <= w_cnt_d;
         r_rddata <= w_rddata_d;
         r_ack    <= w_ack_d;
         r_err    <= w_err_d;
      end
   end

   assign gnt        = r_gnt;
   assign done       = (r_state == StFin) ? r_gnt : '0;
   assign rsp_rddata = r_rddata;
   assign rsp_ack    = r_ack;
   assign rsp_err    = r_err;
   assign m_enable   = r_en;
   assign m_wrdata   = r_wrdata;
   assign m_wrlen    = r_wrlen;
   assign m_rdlen    = r_rdlen;

endmodule
